// File: rtl/ram_bist_pkg.sv
// Shared definitions for the RAM BIST controller: FSM states, the test
// pattern generator and the error-counter width.
package ram_bist_pkg;

    localparam int BIST_ADDR_W = 4;
    localparam int ERR_W       = BIST_ADDR_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

    // Test pattern for address a: a*2, bit-inverted on the inverse pass.
    // The caller truncates the result to its data width.
    function automatic logic [31:0] pattern(input logic [31:0] a, input logic inv);
        logic [31:0] p;
        p = a << 32'd1;
        if (inv) begin
            pattern = ~p;
        end else begin
            pattern = p;
        end
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-back checker for the RAM BIST: aligns the expected value with the
// RAM read latency, compares, counts mismatches (saturating) and captures
// the address of the first mismatch.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mismatch,
    output logic [ADDR_W+1:0] err_count,
    output logic [ADDR_W-1:0] fail_addr
);
    localparam int EW = ADDR_W + 2;

    logic              chk_valid_s;
    logic [DATA_W-1:0] chk_exp_s;
    logic [ADDR_W-1:0] chk_addr_s;
    logic [EW-1:0]     err_count_r;
    logic [ADDR_W-1:0] fail_addr_r;

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign chk_valid_s = rd_valid;
            assign chk_exp_s   = exp_data;
            assign chk_addr_s  = rd_addr;
        end else begin : g_lat1
            logic              valid_d_r;
            logic [DATA_W-1:0] exp_d_r;
            logic [ADDR_W-1:0] addr_d_r;

            // Delay expected data and address to line up with registered read data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_d_r <= 1'b0;
                    exp_d_r   <= {DATA_W{1'b0}};
                    addr_d_r  <= {ADDR_W{1'b0}};
                end else begin
                    valid_d_r <= rd_valid;
                    exp_d_r   <= exp_data;
                    addr_d_r  <= rd_addr;
                end
            end

            assign chk_valid_s = valid_d_r;
            assign chk_exp_s   = exp_d_r;
            assign chk_addr_s  = addr_d_r;
        end
    endgenerate

    assign mismatch = chk_valid_s && (mem_rdata != chk_exp_s);

    // Saturating mismatch counter and first-failure address capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_r <= {EW{1'b0}};
            fail_addr_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            err_count_r <= {EW{1'b0}};
            fail_addr_r <= {ADDR_W{1'b0}};
        end else if (mismatch) begin
            if (err_count_r != {EW{1'b1}}) begin
                err_count_r <= err_count_r + EW'(1);
            end
            if (err_count_r == {EW{1'b0}}) begin
                fail_addr_r <= chk_addr_s;
            end
        end
    end

    assign err_count = err_count_r;
    assign fail_addr = fail_addr_r;

endmodule

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: writes a*2 to every location, reads it all back and
// reports pass/fail, the first failing address and an error count.
// Optional build macro RAM_BIST_INV_PASS_EN adds a second pass using the
// inverted pattern.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W+1:0] err_count,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int                EW        = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    bist_state_e       state_r, state_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic              inv_s, inv_nxt_s, more_pass_s;
    logic              pass_end_s, clear_s, mismatch_s;
    logic [DATA_W-1:0] exp_cur_s, wdata_nxt_s;
    logic [EW-1:0]     err_count_s;
    logic [ADDR_W-1:0] fail_addr_s;
    logic              busy_r, done_r, pass_r, wr_en_r;
    logic [DATA_W-1:0] wdata_r;

`ifdef RAM_BIST_INV_PASS_EN
    logic inv_r;

    // Pass selector: normal pattern first, inverted pattern second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_r <= 1'b0;
        end else begin
            inv_r <= inv_nxt_s;
        end
    end

    // Switch to the inverse pass at the end of the first pass.
    always_comb begin
        inv_nxt_s = inv_r;
        if (clear_s) begin
            inv_nxt_s = 1'b0;
        end else if (pass_end_s && !inv_r) begin
            inv_nxt_s = 1'b1;
        end else begin
            inv_nxt_s = inv_r;
        end
    end

    assign inv_s       = inv_r;
    assign more_pass_s = ~inv_r;
`else
    assign inv_s       = 1'b0;
    assign inv_nxt_s   = 1'b0;
    assign more_pass_s = 1'b0;
`endif

    // A pass ends in DRAIN, or on the last read when the RAM reads combinationally.
    always_comb begin
        pass_end_s = 1'b0;
        if (state_r == ST_DRAIN) begin
            pass_end_s = 1'b1;
        end else if ((state_r == ST_READ) && (addr_r == LAST_ADDR) && (RD_LAT == 0)) begin
            pass_end_s = 1'b1;
        end else begin
            pass_end_s = 1'b0;
        end
    end

    // Next-state and address-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        clear_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WRITE;
                    addr_nxt_s  = {ADDR_W{1'b0}};
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                addr_nxt_s = addr_r + ADDR_W'(1);
                if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_READ: begin
                addr_nxt_s = addr_r + ADDR_W'(1);
                if (pass_end_s) begin
                    state_nxt_s = more_pass_s ? ST_WRITE : ST_DONE;
                end else if (addr_r == LAST_ADDR) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                state_nxt_s = more_pass_s ? ST_WRITE : ST_DONE;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                addr_nxt_s  = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Write data for the coming cycle; zero outside WRITE.
    always_comb begin
        wdata_nxt_s = {DATA_W{1'b0}};
        if (state_nxt_s == ST_WRITE) begin
            wdata_nxt_s = DATA_W'(pattern(32'(addr_nxt_s), inv_nxt_s));
        end else begin
            wdata_nxt_s = {DATA_W{1'b0}};
        end
    end

    assign exp_cur_s = DATA_W'(pattern(32'(addr_r), inv_s));

    // State, address and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            wr_en_r <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            addr_r  <= addr_nxt_s;
            busy_r  <= (state_nxt_s == ST_WRITE) || (state_nxt_s == ST_READ) ||
                       (state_nxt_s == ST_DRAIN);
            done_r  <= (state_nxt_s == ST_DONE);
            wr_en_r <= (state_nxt_s == ST_WRITE);
            wdata_r <= wdata_nxt_s;
            if (clear_s) begin
                pass_r <= 1'b0;
            end else if (state_nxt_s == ST_DONE) begin
                // Include the compare finishing in this very cycle.
                pass_r <= (err_count_s == {EW{1'b0}}) && !mismatch_s;
            end
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear_s),
        .rd_valid  (state_r == ST_READ),
        .rd_addr   (addr_r),
        .exp_data  (exp_cur_s),
        .mem_rdata (mem_rdata),
        .mismatch  (mismatch_s),
        .err_count (err_count_s),
        .fail_addr (fail_addr_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_addr = fail_addr_s;
    assign err_count = err_count_s;
    assign mem_wr_en = wr_en_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl: behavioural RAMs (registered and
// combinational read) with stuck-at-1 fault injection, a write scoreboard
// and result/timing checks.
module tb_ram_bist_ctrl;
    localparam int N = 16;
`ifdef RAM_BIST_INV_PASS_EN
    localparam int NPASS = 2;
    localparam int DONE1 = 67;
    localparam int DONE0 = 65;
`else
    localparam int NPASS = 1;
    localparam int DONE1 = 34;
    localparam int DONE0 = 33;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic start0 = 1'b0;
    always #5 clk = ~clk;

    logic       busy, done, pass, mem_wr_en;
    logic [3:0] fail_addr, mem_addr;
    logic [5:0] err_count;
    logic [7:0] mem_wdata, mem_rdata;

    logic       busy0, done0, pass0, mem_wr_en0;
    logic [3:0] fail_addr0, mem_addr0;
    logic [5:0] err_count0;
    logic [7:0] mem_wdata0, mem_rdata0;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int wr0_cnt = 0;
    logic [1:0]  fault_mode = 2'd0;   // 0 none, 1 address 5 only, 2 all addresses
    logic [7:0]  ram1 [N];
    logic [7:0]  ram0 [N];
    logic [11:0] exp_q [$];
    logic [11:0] mon_e;

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .err_count(err_count), .mem_wr_en(mem_wr_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    ram_bist_ctrl #(.ADDR_W(4), .DATA_W(8), .RD_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_addr(fail_addr0), .err_count(err_count0), .mem_wr_en(mem_wr_en0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
    );

    function automatic logic [7:0] stuck(input logic [3:0] a);
        stuck = ((fault_mode == 2'd2) || ((fault_mode == 2'd1) && (a == 4'd5))) ? 8'h01 : 8'h00;
    endfunction

    // Registered-read RAM with stuck-at-1 cells.
    always @(posedge clk) begin
        if (mem_wr_en) ram1[mem_addr] <= mem_wdata | stuck(mem_addr);
        mem_rdata <= ram1[mem_addr];
    end

    // Combinational-read RAM with stuck-at-1 cells.
    always @(posedge clk) begin
        if (mem_wr_en0) ram0[mem_addr0] <= mem_wdata0 | stuck(mem_addr0);
    end
    assign mem_rdata0 = ram0[mem_addr0];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every RAM write must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (mem_wr_en0) wr0_cnt++;
            if (mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    check("wr_unexpected", {20'd0, mem_addr, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_seq", {20'd0, mem_addr, mem_wdata}, {20'd0, mon_e});
                end
            end
        end
    end

    task automatic push_writes();
        for (int p = 0; p < NPASS; p++) begin
            for (int a = 0; a < N; a++) begin
                logic [7:0] d;
                d = 8'(a * 2);
                if (p == 1) d = ~d;
                exp_q.push_back({4'(a), d});
            end
        end
    endtask

    task automatic run1(input string nm, input logic [1:0] fm, input int exp_err,
                        input int exp_fa, input bit restart_mid);
        int  k;
        int  e_cyc;
        int  dc0;
        bit  got;
        @(negedge clk);
        fault_mode = fm;
        push_writes();
        dc0 = done_cnt;
        e_cyc = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy_e1"}, {31'd0, busy}, 32'd1);
        got = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            k = cyc - e_cyc;
            if (done) begin
                got = 1'b1;
            end else begin
                start = (restart_mid && (k == 10)) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got) begin
            check({nm, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({nm, "_done_cycle"}, k, DONE1);
            check({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
            check({nm, "_pass"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
            check({nm, "_err_count"}, {26'd0, err_count}, exp_err);
            check({nm, "_fail_addr"}, {28'd0, fail_addr}, exp_fa);
        end
        repeat (3) @(negedge clk);
        check({nm, "_done_pulses"}, done_cnt - dc0, 32'd1);
        check({nm, "_writes_left"}, exp_q.size(), 32'd0);
        check({nm, "_pass_held"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
        exp_q.delete();
    endtask

    task automatic run0(input string nm, input logic [1:0] fm, input int exp_err, input int exp_fa);
        int  k;
        int  e_cyc;
        int  w0;
        bit  got;
        @(negedge clk);
        fault_mode = fm;
        w0 = wr0_cnt;
        e_cyc = cyc;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        got = 1'b0;
        k = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            k = cyc - e_cyc;
            if (done0) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            check({nm, "_done_timeout"}, 32'd0, 32'd1);
        end else begin
            check({nm, "_done_cycle"}, k, DONE0);
            check({nm, "_pass"}, {31'd0, pass0}, (exp_err == 0) ? 32'd1 : 32'd0);
            check({nm, "_err_count"}, {26'd0, err_count0}, exp_err);
            check({nm, "_fail_addr"}, {28'd0, fail_addr0}, exp_fa);
            check({nm, "_writes"}, wr0_cnt - w0, N * NPASS);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int dc0;
        #1 rst_n = 1'b0;
        #20;
        check("reset_outs", {6'd0, busy, done, pass, fail_addr, err_count, mem_wr_en, mem_addr, mem_wdata},
              32'd0);
        check("reset_outs0", {6'd0, busy0, done0, pass0, fail_addr0, err_count0, mem_wr_en0, mem_addr0,
              mem_wdata0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run1("clean", 2'd0, 0, 0, 1'b0);
        run1("stuck_a5", 2'd1, 1, 5, 1'b0);
        run1("stuck_all", 2'd2, 16, 0, 1'b0);
        run1("restart_mid", 2'd0, 0, 0, 1'b1);

        // Reset in the middle of a test (read phase, errors accumulating).
        @(negedge clk);
        fault_mode = 2'd2;
        push_writes();
        dc0 = done_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {6'd0, busy, done, pass, fail_addr, err_count, mem_wr_en, mem_addr, mem_wdata},
              32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("rst_mid_no_done", done_cnt - dc0, 32'd0);
        rst_n = 1'b1;
        run1("post_rst", 2'd0, 0, 0, 1'b0);

        run0("lat0_clean", 2'd0, 0, 0);
        run0("lat0_stuck_a5", 2'd1, 1, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
